// File: rtl/iir_mc.sv
// Time-multiplexed multi-channel direct-form-I IIR filter: one serial MAC shared by
// CH channels, per-channel x/y history, round-half-up and saturation on the output.
module iir_mc #(
  parameter int N        = 2,
  parameter int CH       = 4,
  parameter int BITWIDTH = 32,
  parameter int CW       = 32,
  parameter int FAC      = 20,
  parameter int CHW      = (CH > 1) ? $clog2(CH) : 1,
  parameter int AB       = $clog2(2 * N + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [BITWIDTH-1:0] x,
  input  logic        [CHW-1:0]      in_ch,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [BITWIDTH-1:0] y,
  output logic        [CHW-1:0]      out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       coef_we,
  input  logic        [AB-1:0]       coef_addr,
  input  logic signed [CW-1:0]       coef_data,
  output logic        [1:0]          state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready and out_valid are registered and never high together.

  localparam int NT = 2 * N + 1;
  localparam int PW = BITWIDTH + CW;
  localparam int AW = BITWIDTH + CW + AB + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] RND  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic signed [CW-1:0] B0_UNITY = {{(CW-1){1'b0}}, 1'b1} << FAC;
  localparam logic signed [AW-1:0] RHALF    = AW'(1) <<< (FAC - 1);
  localparam logic signed [AW-1:0] YMAX     = (AW'(1) <<< (BITWIDTH - 1)) - AW'(1);
  localparam logic signed [AW-1:0] YMIN     = -(AW'(1) <<< (BITWIDTH - 1));

  logic [1:0]                 state;
  logic [AB-1:0]              tap;
  logic signed [AW-1:0]       acc;
  logic signed [BITWIDTH-1:0] x_lat;
  logic [CHW-1:0]             ch_lat;
  logic signed [CW-1:0]       coef [0:NT-1];
  logic signed [BITWIDTH-1:0] xh   [0:CH-1][0:N-1];
  logic signed [BITWIDTH-1:0] yh   [0:CH-1][0:N-1];

  logic signed [BITWIDTH-1:0] op;
  logic signed [CW-1:0]       cf;
  logic                       sub;
  logic signed [PW-1:0]       prod;
  logic signed [AW-1:0]       prod_ext;
  logic signed [AW-1:0]       rnd;
  logic signed [AW-1:0]       shr;
  logic signed [BITWIDTH-1:0] ysat;

  assign state_dbg = state;

  // Tap i selects x[n-i] for i<=N, y[n-(i-N)] for i>N; feedback taps are subtracted.
  always_comb begin
    op = x_lat;
    cf = '0;
    for (int c = 0; c < CH; c++) begin
      if (int'(ch_lat) == c) begin
        for (int k = 0; k < N; k++) begin
          if (int'(tap) == k + 1)     op = xh[c][k];
          if (int'(tap) == N + 1 + k) op = yh[c][k];
        end
      end
    end
    for (int k = 0; k < NT; k++) begin
      if (int'(tap) == k) cf = coef[k];
    end
    sub = (int'(tap) > N);
  end

  assign prod     = op * cf;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
  assign rnd      = acc + RHALF;
  assign shr      = rnd >>> FAC;

  always_comb begin
    if (shr > YMAX)      ysat = YMAX[BITWIDTH-1:0];
    else if (shr < YMIN) ysat = YMIN[BITWIDTH-1:0];
    else                 ysat = shr[BITWIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tap       <= '0;
      acc       <= '0;
      x_lat     <= '0;
      ch_lat    <= '0;
      in_ready  <= 1'b0;
      y         <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < NT; k++) coef[k] <= (k == 0) ? B0_UNITY : '0;
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < N; k++) begin
          xh[c][k] <= '0;
          yh[c][k] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          // Write lands before the MAC reads, so a same-edge sample sees it.
          if (coef_we) begin
            for (int k = 0; k < NT; k++) begin
              if (int'(coef_addr) == k) coef[k] <= coef_data;
            end
          end
          if (in_ready && in_valid) begin
            x_lat    <= x;
            ch_lat   <= (int'(in_ch) >= CH) ? CHW'(CH - 1) : in_ch;
            acc      <= '0;
            tap      <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
          if (int'(tap) == 2 * N) state <= RND;
          else                    tap   <= tap + 1'b1;
        end
        RND: begin
          y         <= ysat;
          out_ch    <= ch_lat;
          out_valid <= 1'b1;
          for (int c = 0; c < CH; c++) begin
            if (int'(ch_lat) == c) begin
              xh[c][0] <= x_lat;
              yh[c][0] <= ysat;
              for (int k = 1; k < N; k++) begin
                xh[c][k] <= xh[c][k-1];
                yh[c][k] <= yh[c][k-1];
              end
            end
          end
          state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mc.sv
// Directed bench for iir_mc: behavioural filter model feeding an expected queue,
// immediate assertions at every comparison, one summary line at the end.
module tb_iir_mc;

  localparam int N   = 2;
  localparam int CH  = 3;
  localparam int BW  = 16;
  localparam int CW  = 32;
  localparam int FAC = 12;
  localparam int CHW = 2;
  localparam int AB  = 3;

  logic                 clk;
  logic                 rst;
  logic signed [BW-1:0] x;
  logic [CHW-1:0]       in_ch;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] y;
  logic [CHW-1:0]       out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 coef_we;
  logic [AB-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic [1:0]           state_dbg;

  iir_mc #(.N(N), .CH(CH), .BITWIDTH(BW), .CW(CW), .FAC(FAC)) dut (
    .clk(clk), .rst(rst), .x(x), .in_ch(in_ch), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [CHW+BW-1:0] exp_q[$];

  longint mb  [0:2*N];
  longint mxh [0:CH-1][0:N-1];
  longint myh [0:CH-1][0:N-1];

  logic signed [BW-1:0] exp_y;
  logic [CHW-1:0]       exp_ch;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      assert (!(in_ready === 1'b1 && out_valid === 1'b1)) else begin
        failures++;
        $error("FAIL ready_valid_overlap observed=1 expected=0");
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k <= 2 * N; k++) mb[k] = 0;
    mb[0] = longint'(1) <<< FAC;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < N; k++) begin
        mxh[c][k] = 0;
        myh[c][k] = 0;
      end
  endtask

  task automatic push_exp(input longint xv, input int c);
    int cc;
    longint acc;
    longint r;
    cc  = (c >= CH) ? CH - 1 : c;
    acc = mb[0] * xv;
    for (int k = 1; k <= N; k++) begin
      acc += mb[k] * mxh[cc][k-1];
      acc -= mb[N+k] * myh[cc][k-1];
    end
    r = (acc + (longint'(1) <<< (FAC - 1))) >>> FAC;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    for (int k = N - 1; k > 0; k--) begin
      mxh[cc][k] = mxh[cc][k-1];
      myh[cc][k] = myh[cc][k-1];
    end
    mxh[cc][0] = xv;
    myh[cc][0] = r;
    exp_q.push_back({CHW'(cc), BW'(r)});
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_y", y, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_state", state_dbg, 0);
    model_reset();
    exp_q.delete();
    in_valid = 1'b0;
    coef_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", in_ready, 1);
  endtask

  task automatic write_coef(input int addr, input longint data);
    coef_we   = 1'b1;
    coef_addr = AB'(addr);
    coef_data = CW'(data);
    mb[addr]  = data;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic send(input longint xv, input int c, input bit we,
                      input int addr, input longint data);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    if (we) begin
      coef_we   = 1'b1;
      coef_addr = AB'(addr);
      coef_data = CW'(data);
      mb[addr]  = data;
    end
    x        = BW'(xv);
    in_ch    = CHW'(c);
    in_valid = 1'b1;
    push_exp(xv, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic recv(input bit check_lat);
    int lat = 0;
    logic [CHW+BW-1:0] e;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (out_valid !== 1'b1) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    if (check_lat) chk("latency", lat, 2 * N + 2);
    if (exp_q.size() == 0) begin
      chk("unexpected_output", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    exp_y  = $signed(e[BW-1:0]);
    exp_ch = e[BW+:CHW];
    chk("y", y, exp_y);
    chk("out_ch", out_ch, exp_ch);
    chk("in_ready_low_in_out", in_ready, 0);
    if (out_ready === 1'b1) begin
      @(posedge clk);
      #1;
      chk("out_valid_dropped", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
    end
  endtask

  task automatic txn(input longint xv, input int c, input bit check_lat);
    send(xv, c, 1'b0, 0, 0);
    recv(check_lat);
  endtask

  initial begin
    rst = 1'b0; x = '0; in_ch = '0; in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    @(negedge clk);
    do_reset();

    // passthrough, latency, out-of-range channel
    txn(25, 0, 1'b1);
    chk("pass_25", y, 25);
    txn(-56, 2, 1'b1);
    chk("pass_m56", y, -56);
    txn(7, 3, 1'b0);
    chk("clamp_ch", out_ch, 2);

    // reset in the middle of the MAC
    send(100, 1, 1'b0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("in_mac", state_dbg, 1);
    do_reset();
    txn(25, 0, 1'b1);
    chk("after_abort", y, 25);
    do_reset();

    // first-order low-pass, b0 written on the same edge as the first accept
    write_coef(1, 1024);
    write_coef(3, -2048);
    send(100, 0, 1'b1, 0, 1024);
    recv(1'b1);
    chk("lp_first", y, 25);
    txn(-100, 1, 1'b0);
    chk("iso_ch1_first", y, -25);
    txn(100, 0, 1'b0);
    chk("lp_second", y, 63);
    txn(-100, 1, 1'b0);
    chk("iso_ch1_second", y, -62);

    // backpressure with a dropped coefficient write
    out_ready = 1'b0;
    send(0, 0, 1'b0, 0, 0);
    recv(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        coef_we = 1'b1; coef_addr = AB'(0); coef_data = 32'sd8192;
      end
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      chk("bp_y", y, exp_y);
      chk("bp_out_ch", out_ch, exp_ch);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    txn(100, 2, 1'b1);
    chk("old_coef_kept", y, 25);

    // saturation; the feedback term must use the clipped value
    write_coef(0, 16384);
    write_coef(1, 0);
    txn(20000, 1, 1'b0);
    chk("sat_pos", y, 32767);
    txn(0, 1, 1'b0);
    chk("sat_pos_hist", y, 16384);
    txn(-20000, 1, 1'b0);
    chk("sat_neg", y, -32768);
    txn(0, 1, 1'b0);
    chk("sat_neg_hist", y, -16384);

    // random traffic with random output stalls
    for (int i = 0; i < 8; i++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      send(longint'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 3)), 1'b0, 0, 0);
      recv(1'b0);
      if (out_ready !== 1'b1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        chk("rand_hold_y", y, exp_y);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rand_release", out_valid, 0);
      end
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iir_mc.md
# iir_mc

Time-multiplexed, multi-channel, order-N direct-form-I IIR filter with runtime-loadable coefficients and valid/ready handshakes on both sides. It generalises the single-channel iir_N filter in three ways: one serial MAC shared by CH channels, per-channel history storage, and rounding plus saturation of the output. It sits in the sample path between the acquisition front end and downstream decimation, one sample per handshake.

## Interface

- N, 2, filter order (≥1); taps b0..bN, a1..aN
- CH, 4, number of channels (≥1); CHW = max(1, clog2(CH))
- BITWIDTH, 32, signed sample width (x, y)
- CW, 32, signed coefficient width, Q format with FAC fractional bits
- FAC, 20, coefficient fractional bits; must satisfy FAC ≤ CW-2

Ports (clock and reset first):

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- x  in  BITWIDTH  signed input sample
- in_ch  in  CHW  channel of x
- in_valid  in  1  x/in_ch valid
- in_ready  out  1  block can accept a sample
- y  out  BITWIDTH  signed filtered output
- out_ch  out  CHW  channel of y
- out_valid  out  1  y/out_ch valid
- out_ready  in  1  downstream accepts y
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(2N+1)  0..N → b0..bN, N+1..2N → a1..aN
- coef_data  in  CW  signed coefficient

## Operation

- y[n] = sat(round((Σk=0..N bk·x[n-k] − Σk=1..N ak·y[n-k]) / 2^FAC)), evaluated per channel using only that channel's history.
- Accumulator width: BITWIDTH+CW+clog2(2N+1)+1, signed. No accumulator overflow is possible.
- Round: add 2^(FAC-1), then arithmetic right shift by FAC (round half toward +∞).
- Saturate to [−2^(BITWIDTH-1), 2^(BITWIDTH-1)−1]. The y history stores the saturated value.
- History: CH × N past x and CH × N past y registers. Both shift only when a result is produced.
- FSM states:
  - IDLE: in_ready=1. in_valid&in_ready → latch x and in_ch, clear the accumulator, go to MAC.
  - MAC: tap index i = 0..2N, one product accumulated per cycle. After i=2N, go to RND.
  - RND: round/saturate into y, set out_ch, update history, set out_valid=1, go to OUT.
  - OUT: hold y, out_ch, out_valid until out_valid&out_ready, then go to IDLE.
- Coefficient writes take effect only in IDLE, at the clock edge. Writes issued in any other state are dropped.
- Simultaneous coef_we and sample accept in IDLE: the write takes effect, and the accepted sample uses the new coefficient.
- in_ch ≥ CH: the sample is accepted but processed as channel CH-1 (defined, not an error).

## Timing

- Reset (rst low, asynchronous), applied immediately:
  - y=0, out_ch=0, out_valid=0, in_ready=0
  - all history cleared to 0
  - coefficients: b0=2^FAC, all others 0 (passthrough)
  - FSM goes to IDLE
- in_ready is registered and rises at the first clock edge after rst goes high.
- For a sample accepted at edge E:
  - tap i is accumulated at edge E+1+i
  - y and out_valid are registered at edge E+2N+2
- With out_ready held high:
  - the output handshake completes at edge E+2N+3
  - in_ready rises at that edge
  - the next accept is at edge E+2N+4, so the sustained period is 2N+4 cycles
- in_ready and out_valid are never both 1.
- rst asserted mid-MAC or during OUT aborts the sample; no partial history update survives.

## Test plan

- Passthrough after reset (N=1, CH=4, BITWIDTH=32, FAC=20): x=25 on ch0 → y=25 and out_ch=0 exactly 4 edges after accept; x=-56 on ch2 → y=-56.
- First-order low-pass: write b0=b1=2^18 and a1=−2^19, then x=100,100 on ch0 → y=25, then y=63 (62.5 rounded up).
- Channel isolation, same coefficients: interleave ch0 100, ch1 −100, ch0 100, ch1 −100 → outputs 25, −25, 63, −62. The ch1 results show no ch0 contamination.
- Saturation (BITWIDTH=16, FAC=12, CW=32, b0=4·2^12): x=20000 → y=32767; x=−20000 → y=−32768. The next y-history term uses the saturated value.
- Backpressure: out_ready low for 10 cycles → y, out_ch and out_valid stay stable and in_ready=0. A coef_we issued during this window is ignored, verified by the next sample still using the old coefficient. Raising out_ready completes the handshake, and in_ready=1 in the following cycle.
- Mid-operation reset: pull rst low during MAC → out_valid=0 and y=0 immediately. After release, x=25 on ch0 → y=25, confirming passthrough coefficients and cleared history.
